// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and forwarding control for the five-stage pipeline, including
// the multi-cycle M-stage memory wait FSM and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       regA_D,
  input  logic [3:0]       regB_D,
  input  logic             useA_D,
  input  logic             useB_D,
  input  logic [3:0]       regA_E,
  input  logic [3:0]       regB_E,
  input  logic [3:0]       regScr_E,
  input  logic             regw_E,
  input  logic             regmem_E,
  input  logic [3:0]       regScr_M,
  input  logic             regw_M,
  input  logic             regmem_M,
  input  logic             memw_M,
  input  logic             pcload_M,
  input  logic [3:0]       regScr_W,
  input  logic             regw_W,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_W,
  output logic [1:0]       fwdA_E,
  output logic [1:0]       fwdB_E,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {StRun, StMemWait} state_e;

  localparam logic [3:0] CntLoad = 4'(MEM_LAT - 1);
  localparam logic       Multi   = (MEM_LAT > 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             acc_m, busy, load_use;

  assign acc_m = regmem_M | memw_M;
  assign busy  = ((state_q == StRun) & acc_m & Multi) |
                 ((state_q == StMemWait) & (cnt_q > 4'd1));
  assign load_use = regmem_E & regw_E &
                    ((useA_D & (regA_D == regScr_E)) | (useB_D & (regB_D == regScr_E)));

  // A load in M has no result yet, so only ALU results are forwarded from M.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic [3:0] dst_m,
                                         input logic m_ok, input logic [3:0] dst_w,
                                         input logic w_ok);
    if (m_ok && (dst_m == src)) return 2'b10;
    if (w_ok && (dst_w == src)) return 2'b01;
    return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_F && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (acc_m && Multi) begin
          state_d = StMemWait;
          cnt_d   = CntLoad;
        end
      end
      StMemWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    flush_M  = 1'b0;
    flush_W  = 1'b0;
    fwdA_E   = 2'b00;
    fwdB_E   = 2'b00;
    mem_busy = 1'b0;
    if (rst) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
      flush_M = 1'b1;
      flush_W = 1'b1;
    end else begin
      mem_busy = busy;
      fwdA_E   = fwd_sel(regA_E, regScr_M, regw_M & ~regmem_M, regScr_W, regw_W);
      fwdB_E   = fwd_sel(regB_E, regScr_M, regw_M & ~regmem_M, regScr_W, regw_W);
      if (busy) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (pcload_M) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
        flush_M = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a combinational vector table on a MEM_LAT=1
// instance plus multi-cycle sequences on MEM_LAT=3 and MEM_LAT=4 instances.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] regA_D, regB_D, regA_E, regB_E, regScr_E, regScr_M, regScr_W;
  logic       useA_D, useB_D, regw_E, regmem_E, regw_M, regmem_M, memw_M, pcload_M, regw_W;

  // Packed views: st = {F,D,E,M}, fl = {D,E,M,W}
  logic [3:0]  st_m, fl_m, st_1, fl_1, st_4, fl_4;
  logic [1:0]  fwa_m, fwb_m, fwa_1, fwb_1, fwa_4, fwb_4;
  logic        busy_m, busy_1, busy_4;
  logic [15:0] cnt_m, cnt_4;
  logic [3:0]  cnt_1;

  pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(16)) u_main (
    .clk(clk), .rst(rst), .regA_D(regA_D), .regB_D(regB_D), .useA_D(useA_D),
    .useB_D(useB_D), .regA_E(regA_E), .regB_E(regB_E), .regScr_E(regScr_E),
    .regw_E(regw_E), .regmem_E(regmem_E), .regScr_M(regScr_M), .regw_M(regw_M),
    .regmem_M(regmem_M), .memw_M(memw_M), .pcload_M(pcload_M), .regScr_W(regScr_W),
    .regw_W(regw_W), .stall_F(st_m[3]), .stall_D(st_m[2]), .stall_E(st_m[1]),
    .stall_M(st_m[0]), .flush_D(fl_m[3]), .flush_E(fl_m[2]), .flush_M(fl_m[1]),
    .flush_W(fl_m[0]), .fwdA_E(fwa_m), .fwdB_E(fwb_m), .mem_busy(busy_m), .stall_cnt(cnt_m)
  );

  pipe_hazard_ctrl #(.MEM_LAT(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .rst(rst), .regA_D(regA_D), .regB_D(regB_D), .useA_D(useA_D),
    .useB_D(useB_D), .regA_E(regA_E), .regB_E(regB_E), .regScr_E(regScr_E),
    .regw_E(regw_E), .regmem_E(regmem_E), .regScr_M(regScr_M), .regw_M(regw_M),
    .regmem_M(regmem_M), .memw_M(memw_M), .pcload_M(pcload_M), .regScr_W(regScr_W),
    .regw_W(regw_W), .stall_F(st_1[3]), .stall_D(st_1[2]), .stall_E(st_1[1]),
    .stall_M(st_1[0]), .flush_D(fl_1[3]), .flush_E(fl_1[2]), .flush_M(fl_1[1]),
    .flush_W(fl_1[0]), .fwdA_E(fwa_1), .fwdB_E(fwb_1), .mem_busy(busy_1), .stall_cnt(cnt_1)
  );

  pipe_hazard_ctrl #(.MEM_LAT(4), .CNT_W(16)) u_lat4 (
    .clk(clk), .rst(rst), .regA_D(regA_D), .regB_D(regB_D), .useA_D(useA_D),
    .useB_D(useB_D), .regA_E(regA_E), .regB_E(regB_E), .regScr_E(regScr_E),
    .regw_E(regw_E), .regmem_E(regmem_E), .regScr_M(regScr_M), .regw_M(regw_M),
    .regmem_M(regmem_M), .memw_M(memw_M), .pcload_M(pcload_M), .regScr_W(regScr_W),
    .regw_W(regw_W), .stall_F(st_4[3]), .stall_D(st_4[2]), .stall_E(st_4[1]),
    .stall_M(st_4[0]), .flush_D(fl_4[3]), .flush_E(fl_4[2]), .flush_M(fl_4[1]),
    .flush_W(fl_4[0]), .fwdA_E(fwa_4), .fwdB_E(fwb_4), .mem_busy(busy_4), .stall_cnt(cnt_4)
  );

  typedef struct {
    int unsigned d_a, use_a, d_b, use_b;
    int unsigned e_a, e_b, e_dst, e_w, e_ld;
    int unsigned m_dst, m_w, m_ld, pcl;
    int unsigned w_dst, w_w;
    int unsigned x_st, x_fd, x_fe, x_fwa, x_fwb;
  } vec_t;

  localparam int NVec = 13;
  vec_t vecs[NVec];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    {regA_D, regB_D, regA_E, regB_E, regScr_E, regScr_M, regScr_W} = '0;
    {useA_D, useB_D, regw_E, regmem_E, regw_M, regmem_M, memw_M, pcload_M, regw_W} = '0;
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked 3 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_use_a();
    regA_D = 4'd3; useA_D = 1'b1; regScr_E = 4'd3; regw_E = 1'b1; regmem_E = 1'b1;
  endtask

  initial begin
    //            d_a use d_b use  e_a e_b dst w ld  m_dst w ld pcl  w_dst w  st fd fe fwa fwb
    vecs[0]  = '{3, 1, 0, 0,  0, 0, 3, 1, 1,  0, 0, 0, 0,  0, 0,  1, 0, 1, 0, 0};
    vecs[1]  = '{0, 0, 5, 1,  0, 0, 5, 1, 1,  0, 0, 0, 0,  0, 0,  1, 0, 1, 0, 0};
    vecs[2]  = '{3, 0, 0, 0,  0, 0, 3, 1, 1,  0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0};
    vecs[3]  = '{3, 1, 0, 0,  0, 0, 3, 0, 1,  0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0};
    vecs[4]  = '{3, 1, 0, 0,  0, 0, 3, 1, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0};
    vecs[5]  = '{3, 1, 0, 0,  0, 0, 3, 1, 1,  0, 0, 0, 1,  0, 0,  0, 1, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 0,  4, 0, 0, 0, 0,  4, 1, 0, 0,  4, 1,  0, 0, 0, 2, 0};
    vecs[7]  = '{0, 0, 0, 0,  4, 0, 0, 0, 0,  4, 1, 1, 0,  4, 1,  0, 0, 0, 1, 0};
    vecs[8]  = '{0, 0, 0, 0,  0, 7, 0, 0, 0,  0, 0, 0, 0,  7, 1,  0, 0, 0, 0, 1};
    vecs[9]  = '{0, 0, 0, 0,  9, 2, 0, 0, 0,  2, 1, 0, 0,  9, 1,  0, 0, 0, 1, 2};
    vecs[10] = '{0, 0, 0, 0,  4, 4, 0, 0, 0,  4, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1,  0, 0, 0, 1, 1};
    vecs[12] = '{6, 1, 6, 1,  0, 0, 6, 1, 1,  0, 0, 0, 0,  0, 0,  1, 0, 1, 0, 0};

    // Reset: outputs forced even with hazards and forwarding matches on the inputs
    rst = 1'b1;
    clear_in();
    regA_E = 4'd4; regw_M = 1'b1; regScr_M = 4'd4; memw_M = 1'b1; pcload_M = 1'b1;
    load_use_a();
    tick();
    #3;
    chk("reset_stalls", 32'(st_m), 32'h0);
    chk("reset_flushes", 32'(fl_m), 32'hF);
    chk("reset_fwd", 32'({fwa_m, fwb_m}), 32'h0);
    chk("reset_busy", 32'(busy_m), 32'h0);
    tick();
    rst = 1'b0;
    clear_in();
    #3;
    chk("post_reset_cnt", 32'(cnt_m), 32'h0);
    chk("post_reset_idle", 32'({st_m, fl_m, busy_m}), 32'h0);

    // Combinational priority and forwarding table on the single-cycle-memory instance
    for (int i = 0; i < NVec; i++) begin
      tick();
      regA_D = 4'(vecs[i].d_a);  useA_D = 1'(vecs[i].use_a);
      regB_D = 4'(vecs[i].d_b);  useB_D = 1'(vecs[i].use_b);
      regA_E = 4'(vecs[i].e_a);  regB_E = 4'(vecs[i].e_b);
      regScr_E = 4'(vecs[i].e_dst); regw_E = 1'(vecs[i].e_w); regmem_E = 1'(vecs[i].e_ld);
      regScr_M = 4'(vecs[i].m_dst); regw_M = 1'(vecs[i].m_w); regmem_M = 1'(vecs[i].m_ld);
      pcload_M = 1'(vecs[i].pcl);
      regScr_W = 4'(vecs[i].w_dst); regw_W = 1'(vecs[i].w_w);
      #3;
      chk($sformatf("vec%0d", i), 32'({st_1, fl_1, fwa_1, fwb_1, busy_1}),
          32'({1'(vecs[i].x_st), 1'(vecs[i].x_st), 2'b00,
               1'(vecs[i].x_fd), 1'(vecs[i].x_fe), 1'(vecs[i].x_fd), 1'b0,
               2'(vecs[i].x_fwa), 2'(vecs[i].x_fwb), 1'b0}));
    end

    // Load-use: one bubble, then the consumer in E forwards from the load in W
    do_reset();
    load_use_a();
    #3;
    chk("lu_stall", 32'({st_m, fl_m}), 32'hC4);
    tick();
    clear_in();
    regA_E = 4'd3; regScr_W = 4'd3; regw_W = 1'b1;
    #3;
    chk("lu_fwd", 32'(fwa_m), 32'h1);
    chk("lu_nostall", 32'(st_m), 32'h0);
    chk("lu_cnt", 32'(cnt_m), 32'h1);

    // Memory wait, MEM_LAT=3, with a back-to-back second access
    do_reset();
    memw_M = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      #3;
      if (c == 3) begin
        chk("mw_release", 32'({busy_m, st_m, fl_m}), 32'h000);
        chk("mw_cnt", 32'(cnt_m), 32'h2);
      end else begin
        chk($sformatf("mw_busy_c%0d", c), 32'({busy_m, st_m, fl_m}), 32'h1F1);
      end
      chk($sformatf("lat1_idle_c%0d", c), 32'({busy_1, st_1}), 32'h0);
    end

    // Redirect during the wait is honoured only once busy drops
    do_reset();
    memw_M = 1'b1; pcload_M = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      #3;
      chk($sformatf("redir_c%0d", c), 32'({st_m, fl_m}),
          (c == 3) ? 32'h0E : 32'hF1);
    end

    // Reset in the second wait cycle of MEM_LAT=4 abandons the access
    do_reset();
    memw_M = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #3;
    chk("rmw_flushes", 32'(fl_4), 32'hF);
    chk("rmw_stalls_busy", 32'({st_4, busy_4}), 32'h0);
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      #3;
      if (c == 1) chk("rmw_cnt_clr", 32'(cnt_4), 32'h0);
      chk($sformatf("rmw_busy_c%0d", c), 32'(busy_4), (c < 4) ? 32'h1 : 32'h0);
    end
    chk("rmw_cnt", 32'(cnt_4), 32'h3);

    // Saturation of the 4-bit counter under 20 stall cycles
    do_reset();
    load_use_a();
    for (int c = 1; c <= 21; c++) begin
      if (c > 1) tick();
      #3;
      if (c == 11) chk("sat_mid", 32'(cnt_1), 32'd10);
    end
    chk("sat_hold", 32'(cnt_1), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
